// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared constants, the prefetch queue entry type and small PC helpers
//   used by the instruction-fetch front end.
package fetch_unit_pkg;

  // Default first fetch address and bubble encoding.
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // One prefetch queue entry: the PC the instruction was fetched from
  // and the instruction word returned by memory.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Sequential next word address, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo
//   DEPTH-entry synchronous FIFO of fetch entries (PC + instruction).
//   Ports:
//     clk, reset       rising-edge clock, synchronous active-high reset
//     flush_i          drop all entries (pointers and count cleared)
//     push_i, data_i   write one entry
//     pop_i            retire the head entry
//     data_o           head entry (combinational read of the head slot)
//     count_o          number of valid entries
//     full_o, empty_o  occupancy flags
//   Simultaneous push and pop is accepted when full (the freed slot is
//   reused) and when empty (the pop is ignored, the push lands).
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_do;
  logic          pop_do;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_do   = pop_i && !empty_o;
    push_do  = push_i && (!full_o || pop_do);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_do) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_do)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_do) - CW'(pop_do);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_do) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch front end: PC generation, the instruction-memory
//   request/response handshake and an in-order prefetch queue feeding the
//   fetch/decode pipeline register.
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     imem_req, imem_addr   fetch request and its word address (always accepted)
//     imem_ack, imem_data   in-order response, latency >= 1 cycle
//     redirect, redirect_pc flush and restart fetch at a new target
//     stall_D               decode cannot take the head instruction
//     valid_F, instr_F, pc_F  head of the prefetch queue (NOP / 0 when empty)
//   Handshake: memory has no backpressure, so a request is issued in every
//   cycle imem_req=1. Decode consumes the head in every cycle where
//   valid_F=1 and stall_D=0, unless a redirect flushes the queue instead.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_D,
  output logic        valid_F,
  output logic [31:0] instr_F,
  output logic [31:0] pc_F
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;
  logic          q_push;
  logic          q_pop;
  logic          drop_now;
  logic [CW:0]   budget_used;

  fetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    // In-flight requests plus queued entries never exceed the queue size,
    // so every response that is kept always has a free slot.
    budget_used = {1'b0, outstanding_q} + {1'b0, q_count};
    imem_req    = !reset && !redirect && (budget_used < DEPTH_W);
    imem_addr   = fetch_pc_q;

    // Responses are stale if they belong to a pre-redirect request, or if
    // they arrive in the redirect cycle itself.
    drop_now = imem_ack && (redirect || (drop_cnt_q != '0));
    q_push   = imem_ack && !drop_now;
    q_in     = '{pc: resp_pc_q, instr: imem_data};
    q_pop    = valid_F && !stall_D && !redirect;

    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_ack);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;

    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      // Everything still in flight after this edge belongs to the old path.
      drop_cnt_d = outstanding_q - CW'(imem_ack);
    end else begin
      if (imem_req) fetch_pc_d = next_pc(fetch_pc_q);
      if (q_push)   resp_pc_d  = next_pc(resp_pc_q);
      if (drop_now) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign valid_F = !q_empty;
  assign instr_F = valid_F ? q_head.instr : NOP_INSTR;
  assign pc_F    = valid_F ? q_head.pc : 32'h0;

  // A kept response into a full queue means the issue budget was broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(q_push && q_full && !q_pop && !redirect));

endmodule
